// File: rtl/game_sequencer.sv
// Breakout game controller: power-up sync wait, serve, play, miss, game-over and win
// phases, gating ball motion, issuing ball/field reset pulses and tracking lives.
module game_sequencer #(
  parameter int unsigned SYNC_FRAMES  = 240,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned END_FRAMES   = 180,
  parameter int unsigned LIVES        = 3
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       lose,
  input  logic       win,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       field_reset,
  output logic [1:0] lives_left,
  output logic       game_over,
  output logic       game_won,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_MISS      = 3'd3,
    ST_OVER      = 3'd4,
    ST_WON       = 3'd5
  } state_e;

  // Phases end on the tick that brings the frame count up to the parameter value.
  localparam logic [7:0] SYNC_LAST  = 8'(SYNC_FRAMES - 1);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] END_LAST   = 8'(END_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  // Held as a plain vector so the illegal codes 6 and 7 stay representable.
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d;
  logic       vsync_q, lose_q, win_q;
  logic       ball_run_q, ball_run_d;
  logic       ball_reset_q, ball_reset_d;
  logic       field_reset_q, field_reset_d;
  logic       game_over_q, game_over_d;
  logic       game_won_q, game_won_d;

  logic frame_tick, lose_rise, win_rise;

  assign frame_tick = vsync_q & ~vsync;
  assign lose_rise  = lose & ~lose_q;
  assign win_rise   = win & ~win_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lives_d       = lives_q;
    ball_reset_d  = 1'b0;
    field_reset_d = 1'b0;
    if (frame_tick) cnt_d = cnt_q + 8'd1;

    case (state_q)
      ST_WAIT_SYNC: begin
        if (frame_tick && cnt_q == SYNC_LAST) begin
          state_d       = ST_SERVE;
          ball_reset_d  = 1'b1;
          field_reset_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick && cnt_q == SERVE_LAST) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (win_rise) begin
          state_d = ST_WON;
        end else if (lose_rise) begin
          if (lives_q == 2'd1) begin
            state_d = ST_OVER;
            lives_d = 2'd0;
          end else begin
            state_d = ST_MISS;
            lives_d = lives_q - 2'd1;
          end
        end
      end
      ST_MISS: begin
        state_d      = ST_SERVE;
        ball_reset_d = 1'b1;
      end
      ST_OVER, ST_WON: begin
        if (frame_tick && cnt_q == END_LAST) begin
          state_d       = ST_SERVE;
          lives_d       = LIVES_INIT;
          ball_reset_d  = 1'b1;
          field_reset_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_SYNC;
    endcase

    if (state_d != state_q) cnt_d = 8'd0;

    // Outputs decode the next state so they line up with the state register.
    ball_run_d  = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
    game_won_d  = (state_d == ST_WON);
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_WAIT_SYNC;
      cnt_q         <= 8'd0;
      lives_q       <= LIVES_INIT;
      vsync_q       <= 1'b1;
      lose_q        <= 1'b1;
      win_q         <= 1'b1;
      ball_run_q    <= 1'b0;
      ball_reset_q  <= 1'b0;
      field_reset_q <= 1'b0;
      game_over_q   <= 1'b0;
      game_won_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lives_q       <= lives_d;
      vsync_q       <= vsync;
      lose_q        <= lose;
      win_q         <= win;
      ball_run_q    <= ball_run_d;
      ball_reset_q  <= ball_reset_d;
      field_reset_q <= field_reset_d;
      game_over_q   <= game_over_d;
      game_won_q    <= game_won_d;
    end
  end

  assign state       = state_q;
  assign lives_left  = lives_q;
  assign ball_run    = ball_run_q;
  assign ball_reset  = ball_reset_q;
  assign field_reset = field_reset_q;
  assign game_over   = game_over_q;
  assign game_won    = game_won_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short frame parameters and hand-computed
// expectations for state, lives, ball_run and reset pulse counts.
module tb_game_sequencer;

  logic       pxl_clk;
  logic       reset_n;
  logic       vsync;
  logic       lose;
  logic       win;
  logic       ball_run;
  logic       ball_reset;
  logic       field_reset;
  logic [1:0] lives_left;
  logic       game_over;
  logic       game_won;
  logic [2:0] state;

  int n_vec;
  int n_err;
  int br_cnt;
  int fr_cnt;

  game_sequencer #(
    .SYNC_FRAMES (4),
    .SERVE_FRAMES(2),
    .END_FRAMES  (3),
    .LIVES       (3)
  ) dut (
    .pxl_clk    (pxl_clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .lose       (lose),
    .win        (win),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .field_reset(field_reset),
    .lives_left (lives_left),
    .game_over  (game_over),
    .game_won   (game_won),
    .state      (state)
  );

  // clock / reset
  initial pxl_clk = 1'b0;
  always #20 pxl_clk = ~pxl_clk;

  // pulse counters sampled away from the active edge
  always @(negedge pxl_clk) begin
    if (ball_reset)  br_cnt++;
    if (field_reset) fr_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge pxl_clk);
  endtask

  // one vsync frame: low for a cycle, then back high for a cycle
  task automatic tick();
    vsync = 1'b0;
    cycle();
    vsync = 1'b1;
    cycle();
  endtask

  task automatic lose_pulse();
    lose = 1'b1;
    cycle();
    lose = 1'b0;
  endtask

  task automatic serve_to_play(input string tag);
    tick();
    check({tag, "_serve_run"}, int'(ball_run), 0);
    check({tag, "_serve_state"}, int'(state), 1);
    tick();
    check({tag, "_play_state"}, int'(state), 2);
    check({tag, "_play_run"}, int'(ball_run), 1);
  endtask

  int br0;
  int fr0;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    br_cnt  = 0;
    fr_cnt  = 0;
    reset_n = 1'b0;
    vsync   = 1'b1;
    lose    = 1'b1;
    win     = 1'b0;
    repeat (3) cycle();

    check("rst_state", int'(state), 0);
    check("rst_run", int'(ball_run), 0);
    check("rst_lives", int'(lives_left), 3);
    check("rst_over", int'(game_over), 0);
    check("rst_won", int'(game_won), 0);
    check("rst_breset", int'(ball_reset), 0);
    check("rst_freset", int'(field_reset), 0);
    reset_n = 1'b1;
    cycle();

    // power-up wait with lose held high from reset
    br0 = br_cnt; fr0 = fr_cnt;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("sync_state", int'(state), 0);
      check("sync_run", int'(ball_run), 0);
    end
    tick();
    check("sync_done_state", int'(state), 1);
    check("sync_breset_cnt", br_cnt - br0, 1);
    check("sync_freset_cnt", fr_cnt - fr0, 1);
    check("held_lose_lives", int'(lives_left), 3);

    // lose edge during SERVE is ignored
    lose = 1'b0;
    cycle();
    lose = 1'b1;
    cycle();
    lose = 1'b0;
    check("serve_lose_lives", int'(lives_left), 3);
    check("serve_lose_state", int'(state), 1);
    serve_to_play("p1");

    // lose 1: PLAY -> MISS -> SERVE
    br0 = br_cnt;
    lose_pulse();
    check("miss1_state", int'(state), 3);
    check("miss1_lives", int'(lives_left), 2);
    check("miss1_run", int'(ball_run), 0);
    cycle();
    check("miss1_serve", int'(state), 1);
    serve_to_play("p2");
    check("miss1_breset_cnt", br_cnt - br0, 1);

    // lose 2
    lose_pulse();
    check("miss2_state", int'(state), 3);
    check("miss2_lives", int'(lives_left), 1);
    cycle();
    serve_to_play("p3");

    // lose 3: game over
    br0 = br_cnt; fr0 = fr_cnt;
    lose_pulse();
    check("over_state", int'(state), 4);
    check("over_lives", int'(lives_left), 0);
    check("over_flag", int'(game_over), 1);
    check("over_run", int'(ball_run), 0);
    tick();
    tick();
    check("over_hold", int'(state), 4);
    tick();
    check("over_exit_state", int'(state), 1);
    check("over_exit_lives", int'(lives_left), 3);
    check("over_exit_flag", int'(game_over), 0);
    check("over_breset_cnt", br_cnt - br0, 1);
    check("over_freset_cnt", fr_cnt - fr0, 1);
    serve_to_play("p4");

    // win and lose together: win has priority, lives untouched
    br0 = br_cnt; fr0 = fr_cnt;
    win  = 1'b1;
    lose = 1'b1;
    cycle();
    win  = 1'b0;
    lose = 1'b0;
    check("won_state", int'(state), 5);
    check("won_flag", int'(game_won), 1);
    check("won_lives", int'(lives_left), 3);
    tick();
    tick();
    check("won_hold", int'(state), 5);
    tick();
    check("won_exit_state", int'(state), 1);
    check("won_exit_flag", int'(game_won), 0);
    check("won_breset_cnt", br_cnt - br0, 1);
    check("won_freset_cnt", fr_cnt - fr0, 1);
    serve_to_play("p5");

    // illegal state code recovers to WAIT_SYNC
    force dut.state_q = 3'd7;
    #1;
    release dut.state_q;
    check("illegal_forced", int'(state), 7);
    cycle();
    check("illegal_state", int'(state), 0);
    check("illegal_run", int'(ball_run), 0);

    // back to PLAY, lose a life, then asynchronous reset mid-game
    repeat (4) tick();
    check("resync_state", int'(state), 1);
    serve_to_play("p6");
    lose_pulse();
    cycle();
    serve_to_play("p7");
    check("pre_reset_lives", int'(lives_left), 2);
    @(posedge pxl_clk);
    #5;
    reset_n = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_run", int'(ball_run), 0);
    check("async_lives", int'(lives_left), 3);
    check("async_over", int'(game_over), 0);
    cycle();
    reset_n = 1'b1;
    cycle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("post_reset_wait", int'(state), 0);
    end
    tick();
    check("post_reset_serve", int'(state), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
